// File: rtl/program_loader.sv
// Serial boot loader: receives a length-prefixed, checksummed byte image and
// writes it word by word into instruction memory.
module program_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   word_count
);

  localparam int          MAX_WORDS = 1 << ADDR_W;
  localparam logic [16:0] MAX_LEN   = 17'(MAX_WORDS);

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERROR} state_t;

  state_t      state, state_nx;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [15:0] len_in;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
  logic [7:0]  sum;
  logic        accept, kick, last_word;

  assign accept    = rx_valid && rx_ready;
  assign kick      = start && (state == IDLE || state == DONE || state == ERROR);
  assign len_in    = {rx_data, len_lo};
  assign last_word = (32'(word_count) + 32'd1) == 32'(len);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rx_ready = 1'b0;
    case (state)
      IDLE, DONE, ERROR: if (start) state_nx = LEN0;
      LEN0: begin
        rx_ready = 1'b1;
        if (accept) state_nx = LEN1;
      end
      LEN1: begin
        rx_ready = 1'b1;
        if (accept) begin
          if ({1'b0, len_in} > MAX_LEN) state_nx = ERROR;
          else if (len_in == 16'd0)     state_nx = CSUM;
          else                          state_nx = DATA;
        end
      end
      DATA: begin
        rx_ready = 1'b1;
        if (accept && byte_idx == 2'd3 && last_word) state_nx = CSUM;
      end
      CSUM: begin
        rx_ready = 1'b1;
        if (accept) state_nx = (rx_data == sum) ? DONE : ERROR;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      len_lo     <= '0;
      len        <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
      sum        <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      word_count <= '0;
    end else begin
      mem_we <= 1'b0;
      if (kick) begin
        load_done  <= 1'b0;
        load_error <= 1'b0;
        word_count <= '0;
        byte_idx   <= '0;
        sum        <= '0;
        mem_addr   <= '0;
      end
      if (accept) begin
        case (state)
          LEN0: len_lo <= rx_data;
          LEN1: begin
            len <= len_in;
            if ({1'b0, len_in} > MAX_LEN) load_error <= 1'b1;
          end
          DATA: begin
            sum      <= sum + rx_data;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= rx_data;
              2'd1: word_buf[15:8]  <= rx_data;
              2'd2: word_buf[23:16] <= rx_data;
              default: begin
                // word index doubles as the write address
                mem_we     <= 1'b1;
                mem_addr   <= word_count[ADDR_W-1:0];
                mem_wdata  <= {rx_data, word_buf};
                word_count <= word_count + 1'b1;
              end
            endcase
          end
          CSUM: begin
            load_done  <= (rx_data == sum);
            load_error <= (rx_data != sum);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: images are built as byte queues, writes
// are captured from the memory port and compared with hand-derived values.
module tb_program_loader;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0, reset_n = 1'b0, start = 1'b0, rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready, mem_we, load_done, load_error;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   word_count;

  int total = 0, passed = 0;
  logic [7:0]        img[$];
  logic [ADDR_W-1:0] wa[$];
  logic [31:0]       wd[$];
  logic [79:0]       a_bytes = 80'h02_00_13_00_00_00_93_00_10_00;

  program_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .load_done(load_done),
    .load_error(load_error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_we) begin
    wa.push_back(mem_addr);
    wd.push_back(mem_wdata);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rx_ready_wait", rx_ready, 1'b1);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_range(input int lo, input int hi, input int gap);
    for (int i = lo; i < hi; i++) send(img[i], gap);
  endtask

  task automatic load_a();
    img.delete();
    for (int i = 0; i < 10; i++) img.push_back(a_bytes[79-8*i -: 8]);
  endtask

  // payload sum starts after the two length bytes
  task automatic add_csum(input logic [7:0] delta);
    logic [7:0] s = 8'h00;
    for (int i = 2; i < img.size(); i++) s = s + img[i];
    img.push_back(s + delta);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wa.delete();
    wd.delete();
  endtask

  task automatic check_two(input string t);
    chk({t, "_nwrites"}, wa.size(), 2);
    if (wa.size() == 2) begin
      chk({t, "_addr0"}, wa[0], 0);
      chk({t, "_data0"}, wd[0], 32'h0000_0013);
      chk({t, "_addr1"}, wa[1], 1);
      chk({t, "_data1"}, wd[1], 32'h0010_0093);
    end
    chk({t, "_word_count"}, word_count, 2);
  endtask

  task automatic check_reset(input string t);
    chk({t, "_rx_ready"}, rx_ready, 1'b0);
    chk({t, "_mem_we"}, mem_we, 1'b0);
    chk({t, "_mem_addr"}, mem_addr, 0);
    chk({t, "_mem_wdata"}, mem_wdata, 0);
    chk({t, "_done"}, load_done, 1'b0);
    chk({t, "_error"}, load_error, 1'b0);
    chk({t, "_word_count"}, word_count, 0);
  endtask

  initial begin
    int bad;
    // reset state, then bytes offered before any start are refused
    repeat (3) @(negedge clk);
    check_reset("rst");
    reset_n  = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    repeat (5) @(negedge clk);
    chk("pre_start_ready", rx_ready, 1'b0);
    chk("pre_start_writes", wa.size(), 0);
    rx_valid = 1'b0;

    // two-word image, good checksum (13+93+10 = B6)
    pulse_start();
    load_a();
    add_csum(8'h00);
    chk("a_csum_byte", img[10], 8'hB6);
    send_range(0, img.size(), 0);
    repeat (3) @(negedge clk);
    check_two("a");
    chk("a_done", load_done, 1'b1);
    chk("a_error", load_error, 1'b0);
    chk("a_ready_idle", rx_ready, 1'b0);

    // same image, checksum off by one
    pulse_start();
    chk("b_done_cleared", load_done, 1'b0);
    load_a();
    add_csum(8'h01);
    send_range(0, img.size(), 0);
    repeat (3) @(negedge clk);
    check_two("b");
    chk("b_done", load_done, 1'b0);
    chk("b_error", load_error, 1'b1);

    // empty image
    pulse_start();
    img.delete();
    img.push_back(8'h00);
    img.push_back(8'h00);
    add_csum(8'h00);
    send_range(0, img.size(), 0);
    repeat (3) @(negedge clk);
    chk("c_nwrites", wa.size(), 0);
    chk("c_done", load_done, 1'b1);
    chk("c_error", load_error, 1'b0);
    chk("c_word_count", word_count, 0);

    // length 1025 exceeds capacity
    pulse_start();
    send(8'h01, 0);
    send(8'h04, 0);
    chk("d_ready_after_len", rx_ready, 1'b0);
    chk("d_error", load_error, 1'b1);
    chk("d_done", load_done, 1'b0);
    rx_valid = 1'b1;
    rx_data  = 8'h13;
    repeat (4) @(negedge clk);
    chk("d_ready_hold", rx_ready, 1'b0);
    chk("d_nwrites", wa.size(), 0);
    rx_valid = 1'b0;

    // long stalls between bytes
    pulse_start();
    load_a();
    add_csum(8'h00);
    send_range(0, img.size(), 20);
    repeat (3) @(negedge clk);
    check_two("e");
    chk("e_done", load_done, 1'b1);

    // reset lands on the edge that accepts the last byte of word 1
    pulse_start();
    load_a();
    add_csum(8'h00);
    send_range(0, 9, 0);
    @(negedge clk);
    rx_data  = img[9];
    rx_valid = 1'b1;
    reset_n  = 1'b0;
    @(negedge clk);
    check_reset("f_rst");
    chk("f_writes_before_rst", wa.size(), 1);
    rx_valid = 1'b0;
    reset_n  = 1'b1;
    pulse_start();
    send_range(0, img.size(), 0);
    repeat (3) @(negedge clk);
    check_two("f");
    chk("f_done", load_done, 1'b1);

    // start pulse mid-payload is ignored
    pulse_start();
    send_range(0, 4, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_range(4, img.size(), 0);
    repeat (3) @(negedge clk);
    check_two("g");
    chk("g_done", load_done, 1'b1);

    // start from DONE restarts immediately
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("h_done_dropped", load_done, 1'b0);
    chk("h_ready_len0", rx_ready, 1'b1);
    chk("h_word_count", word_count, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    repeat (2) @(negedge clk);
    chk("h_done", load_done, 1'b1);

    // full capacity: 1024 words of byte pattern i[7:0]
    pulse_start();
    img.delete();
    img.push_back(8'h00);
    img.push_back(8'h04);
    for (int i = 0; i < 4096; i++) img.push_back(8'(i));
    add_csum(8'h00);
    send_range(0, img.size(), 0);
    repeat (3) @(negedge clk);
    chk("max_nwrites", wa.size(), 1024);
    bad = 0;
    for (int i = 0; i < wa.size(); i++) if (wa[i] !== 10'(i)) bad++;
    chk("max_addr_seq", bad, 0);
    if (wa.size() == 1024) begin
      chk("max_last_addr", wa[1023], 10'd1023);
      chk("max_last_data", wd[1023], 32'hFFFE_FDFC);
      chk("max_first_data", wd[0], 32'h0302_0100);
    end
    chk("max_word_count", word_count, 1024);
    chk("max_done", load_done, 1'b1);
    chk("max_error", load_error, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
